// File: rtl/appx_div16_8_pkg.sv
// Shared types and constants for the approximate-arithmetic divider slice.
// Holds the divider FSM encoding and the midpoint-compensation helper.
package appx_arith_pkg;
  localparam int QW = 8;
  localparam int MW = $clog2(QW);
  localparam int CW = $clog2(QW + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} div_state_t;

  localparam logic [QW-1:0] Q_SAT = '1;
  localparam logic [QW-1:0] R_DZ  = '1;

  // Restore the skipped low quotient bits as their midpoint (0b100..0).
  function automatic logic [QW-1:0] midpoint_fix(input logic [QW-1:0] q,
                                                 input logic [MW-1:0] k);
    logic [QW-1:0] c;
    c = '0;
    if (k != '0) c[k - MW'(1)] = 1'b1;
    return (q << k) | c;
  endfunction
endpackage

// File: rtl/appx_div16_8_if.sv
// Operand/result bundle for the divider.
// Both sides follow valid/ready: a transfer happens on a rising edge where valid and ready are both high.
interface appx_div16_8_if;
  import appx_arith_pkg::*;
  logic              in_valid;
  logic              in_ready;
  logic [2*QW-1:0]   dat_in_a;
  logic [QW-1:0]     dat_in_b;
  logic [MW-1:0]     mask;
  logic              out_valid;
  logic              out_ready;
  logic [QW-1:0]     dat_o_q;
  logic [QW-1:0]     dat_o_r;
  logic              div_zero;
  logic              ovf;

  modport master (
    output in_valid, dat_in_a, dat_in_b, mask, out_ready,
    input  in_ready, out_valid, dat_o_q, dat_o_r, div_zero, ovf
  );

  modport slave (
    input  in_valid, dat_in_a, dat_in_b, mask, out_ready,
    output in_ready, out_valid, dat_o_q, dat_o_r, div_zero, ovf
  );
endinterface

// File: rtl/appx_div16_8_step.sv
// One combinational restoring-division iteration.
// The 8-bit subtract is enough because a successful step always leaves a result below b.
module appx_div_step
  import appx_arith_pkg::*;
(
  input  logic [QW-1:0] prem,
  input  logic          bit_in,
  input  logic [QW-1:0] b,
  output logic [QW-1:0] prem_nxt,
  output logic          qbit
);
  logic [QW:0] t;

  assign t        = {prem, bit_in};
  assign qbit     = (t >= {1'b0, b});
  assign prem_nxt = qbit ? (t[QW-1:0] - b) : t[QW-1:0];
endmodule

// File: rtl/appx_div16_8.sv
// Sequential 16/8 restoring divider with optional low-bit skipping (mask)
// and midpoint compensation of the skipped quotient bits.
module appx_div16_8
  import appx_arith_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  appx_div16_8_if.slave        bus,
  output div_state_t           state_dbg
);
  div_state_t      state, state_nxt;
  logic [QW-1:0]   b_r, prem, sh, q_run;
  logic [MW-1:0]   k_r;
  logic [CW-1:0]   cnt;
  logic [QW-1:0]   q_o, r_o;
  logic            dz_o, ovf_o;
  logic [QW-1:0]   step_prem;
  logic            step_qbit;
  logic            accept;
  logic [QW-1:0]   hi, lo;

  assign hi     = bus.dat_in_a[2*QW-1:QW];
  assign lo     = bus.dat_in_a[QW-1:0];
  assign accept = bus.in_valid && bus.in_ready;

  assign bus.in_ready  = (state == IDLE) && !rst;
  assign bus.out_valid = (state == DONE);
  assign bus.dat_o_q   = q_o;
  assign bus.dat_o_r   = r_o;
  assign bus.div_zero  = dz_o;
  assign bus.ovf       = ovf_o;
  assign state_dbg     = state;

  appx_div_step u_step (
    .prem     (prem),
    .bit_in   (sh[QW-1]),
    .b        (b_r),
    .prem_nxt (step_prem),
    .qbit     (step_qbit)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) begin
        if (bus.dat_in_b == '0 || hi >= bus.dat_in_b) state_nxt = DONE;
        else                                          state_nxt = RUN;
      end
      RUN:  if (cnt == CW'(1)) state_nxt = DONE;
      DONE: if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operands, iteration state and result registers; k is captured at accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      b_r   <= '0;
      prem  <= '0;
      sh    <= '0;
      q_run <= '0;
      k_r   <= '0;
      cnt   <= '0;
      q_o   <= '0;
      r_o   <= '0;
      dz_o  <= 1'b0;
      ovf_o <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          k_r   <= bus.mask;
          cnt   <= CW'(QW) - CW'(bus.mask);
          b_r   <= bus.dat_in_b;
          prem  <= hi;
          sh    <= lo;
          q_run <= '0;
          if (bus.dat_in_b == '0) begin
            q_o   <= Q_SAT;
            r_o   <= R_DZ;
            dz_o  <= 1'b1;
            ovf_o <= 1'b0;
          end else if (hi >= bus.dat_in_b) begin
            q_o   <= Q_SAT;
            r_o   <= '0;
            dz_o  <= 1'b0;
            ovf_o <= 1'b1;
          end else begin
            dz_o  <= 1'b0;
            ovf_o <= 1'b0;
          end
        end
        RUN: begin
          prem  <= step_prem;
          sh    <= sh << 1;
          q_run <= {q_run[QW-2:0], step_qbit};
          cnt   <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            q_o <= midpoint_fix({q_run[QW-2:0], step_qbit}, k_r);
            r_o <= step_prem;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_appx_div16_8.sv
// Directed-vector bench for appx_div16_8 plus backpressure, mid-run reset and a randomized sweep.
module tb_appx_div16_8;
  import appx_arith_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  div_state_t state_dbg;

  appx_div16_8_if bus();

  appx_div16_8 dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [7:0]  b;
    logic [2:0]  m;
    logic [7:0]  q;
    logic [7:0]  r;
    logic        dz;
    logic        ovf;
    int          lat;
  } vec_t;

  vec_t        vecs[13];
  logic [17:0] exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drives one operation with out_ready high; returns outputs sampled while out_valid.
  task automatic do_op(input logic [15:0] a, input logic [7:0] b, input logic [2:0] m,
                       output logic [7:0] q, output logic [7:0] r, output logic dz,
                       output logic ovf, output int lat, output logic busy_ok);
    int guard;
    @(negedge clk);
    guard = 0;
    while (!bus.in_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("in_ready_idle", bus.in_ready, 1);
    bus.dat_in_a  = a;
    bus.dat_in_b  = b;
    bus.mask      = m;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.mask     = ~m;
    busy_ok      = 1'b1;
    while (!bus.out_valid && lat < 20) begin
      if (bus.in_ready) busy_ok = 1'b0;
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    q   = bus.dat_o_q;
    r   = bus.dat_o_r;
    dz  = bus.div_zero;
    ovf = bus.ovf;
  endtask

  task automatic run_and_score(input string tag, input logic [15:0] a, input logic [7:0] b,
                               input logic [2:0] m, input int exp_lat);
    logic [7:0]  q, r;
    logic        dz, ovf, busy_ok;
    int          lat;
    logic [17:0] e;
    do_op(a, b, m, q, r, dz, ovf, lat, busy_ok);
    e = exp_q.pop_front();
    check({tag, "_q"},    q,   e[17:10]);
    check({tag, "_r"},    r,   e[9:2]);
    check({tag, "_dz"},   dz,  e[1]);
    check({tag, "_ovf"},  ovf, e[0]);
    check({tag, "_lat"},  lat, exp_lat);
    check({tag, "_busy"}, busy_ok, 1);
  endtask

  initial begin
    logic [7:0]  q0, r0, rb, rhi, rlo;
    logic [2:0]  rk;
    logic [15:0] ra, sa;
    logic [7:0]  eq, er;
    logic        stable;
    int          guard;

    vecs[0]  = '{16'd1000,  8'd7,   3'd0, 8'd142, 8'd6,   1'b0, 1'b0, 9};
    vecs[1]  = '{16'd1000,  8'd7,   3'd2, 8'd142, 8'd5,   1'b0, 1'b0, 7};
    vecs[2]  = '{16'h1234,  8'd0,   3'd0, 8'hFF,  8'hFF,  1'b1, 1'b0, 1};
    vecs[3]  = '{16'h0800,  8'd8,   3'd0, 8'hFF,  8'h00,  1'b0, 1'b1, 1};
    vecs[4]  = '{16'd255,   8'd16,  3'd0, 8'd15,  8'd15,  1'b0, 1'b0, 9};
    vecs[5]  = '{16'd0,     8'd5,   3'd0, 8'd0,   8'd0,   1'b0, 1'b0, 9};
    vecs[6]  = '{16'd0,     8'd5,   3'd3, 8'd4,   8'd0,   1'b0, 1'b0, 6};
    vecs[7]  = '{16'd200,   8'd1,   3'd0, 8'd200, 8'd0,   1'b0, 1'b0, 9};
    vecs[8]  = '{16'd1000,  8'd7,   3'd7, 8'd192, 8'd0,   1'b0, 1'b0, 2};
    vecs[9]  = '{16'h7FFF,  8'h80,  3'd0, 8'd255, 8'd127, 1'b0, 1'b0, 9};
    vecs[10] = '{16'h00FF,  8'hFF,  3'd0, 8'd1,   8'd0,   1'b0, 1'b0, 9};
    vecs[11] = '{16'hFE01,  8'hFF,  3'd0, 8'd255, 8'd0,   1'b0, 1'b0, 9};
    vecs[12] = '{16'd1000,  8'd7,   3'd1, 8'd143, 8'd3,   1'b0, 1'b0, 8};

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.dat_in_a  = '0;
    bus.dat_in_b  = '0;
    bus.mask      = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready",  bus.in_ready, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_q",         bus.dat_o_q, 0);
    check("rst_r",         bus.dat_o_r, 0);
    check("rst_flags",     {bus.div_zero, bus.ovf}, 0);
    check("rst_state",     state_dbg, IDLE);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", bus.in_ready, 1);

    for (int i = 0; i < 13; i++) begin
      exp_q.push_back({vecs[i].q, vecs[i].r, vecs[i].dz, vecs[i].ovf});
      run_and_score($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].m, vecs[i].lat);
    end

    // Backpressure: result must hold while out_ready is low.
    @(negedge clk);
    bus.dat_in_a  = 16'd1000;
    bus.dat_in_b  = 8'd7;
    bus.mask      = 3'd0;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    guard = 0;
    while (!bus.out_valid && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("bp_reached_done", bus.out_valid, 1);
    q0 = bus.dat_o_q;
    r0 = bus.dat_o_r;
    check("bp_q", q0, 142);
    check("bp_r", r0, 6);
    stable = 1'b1;
    repeat (5) begin
      @(posedge clk);
      @(negedge clk);
      if (!bus.out_valid || bus.dat_o_q !== q0 || bus.dat_o_r !== r0 || bus.in_ready) stable = 1'b0;
    end
    check("bp_stable", stable, 1);
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp_out_valid_clr", bus.out_valid, 0);
    check("bp_state_idle",    state_dbg, IDLE);
    check("bp_in_ready",      bus.in_ready, 1);
    check("bp_q_kept",        bus.dat_o_q, 142);

    // Reset during the third iteration aborts the operation.
    bus.dat_in_a = 16'd1000;
    bus.dat_in_b = 8'd7;
    bus.mask     = 3'd0;
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("mid_state_run", state_dbg, RUN);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_in_ready", bus.in_ready, 0);
    rst = 1'b0;
    check("mid_rst_state",     state_dbg, IDLE);
    check("mid_rst_out_valid", bus.out_valid, 0);
    check("mid_rst_q",         bus.dat_o_q, 0);
    check("mid_rst_r",         bus.dat_o_r, 0);
    check("mid_rst_flags",     {bus.div_zero, bus.ovf}, 0);
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_no_result", bus.out_valid, 0);
    exp_q.push_back({8'd15, 8'd15, 1'b0, 1'b0});
    run_and_score("after_rst", 16'd255, 8'd16, 3'd0, 9);

    // Randomized sweep against an arithmetic reference.
    for (int i = 0; i < 200; i++) begin
      rb  = 8'($urandom_range(1, 255));
      rhi = 8'($urandom_range(0, int'(rb) - 1));
      rlo = 8'($urandom_range(0, 255));
      rk  = (i < 60) ? 3'd0 : 3'($urandom_range(0, 7));
      ra  = {rhi, rlo};
      sa  = ra >> rk;
      eq  = 8'((sa / 16'(rb)) << rk);
      if (rk != 3'd0) eq = eq | 8'(1 << (rk - 3'd1));
      er  = 8'(sa % 16'(rb));
      exp_q.push_back({eq, er, 1'b0, 1'b0});
      run_and_score($sformatf("rnd%0d", i), ra, rb, rk, 9 - int'(rk));
    end

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
